fft4_stream_ctrl: RTL and testbench
===================================

Name: fft4_stream_ctrl

Overview:
Sequencer that turns the combinational fft4 datapath into a streaming, handshaked block. It collects four complex samples from a valid/ready input stream and presents them in parallel to an internal fft4 instance. It registers the four results and replays them one per beat on a valid/ready output stream. It sits between a sample source (ADC/test driver) and downstream consumers.

Parameters:
W, 16, signed width of input real/imag parts; fft4 inputs are W bits, fft4 outputs are W+2 bits.
CNT_W, 16, width of frame counter.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
s_valid  input  1  input sample valid
s_ready  output  1  controller accepts input sample
s_re  input  W  input sample real, signed
s_im  input  W  input sample imag, signed
m_valid  output  1  output bin valid
m_ready  input  1  consumer accepts output bin
m_re  output  W+2  output bin real, signed
m_im  output  W+2  output bin imag, signed
m_idx  output  2  bin index k of current output (0..3)
m_last  output  1  high with bin 3
busy  output  1  high in COMPUTE or UNLOAD
frame_cnt  output  CNT_W  completed frames (bin 3 handshaked)

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). All state updates on rising clk; rst has priority over every other event.
- Reset values: state=LOAD, load index 0, out index 0, m_valid=0, m_re=m_im=0, m_idx=0, m_last=0, busy=0, frame_cnt=0, s_ready=1 (first cycle after rst deasserts).
- States: LOAD, COMPUTE, UNLOAD.
- LOAD:
  - s_ready=1.
  - On s_valid&&s_ready, store sample into x[load_idx] and increment load_idx.
  - On the 4th accept (load_idx==3), go to COMPUTE and wrap load_idx to 0.
  - Partial frames are held indefinitely; gaps in s_valid are allowed.
- COMPUTE:
  - Lasts exactly 1 cycle; s_ready=0, m_valid=0.
  - Latch fft4 outputs y0..y3 (W+2 bits, sign-extended by fft4) into result registers.
  - Go to UNLOAD.
- UNLOAD:
  - s_ready=0, m_valid=1.
  - m_re/m_im/m_idx present y[out_idx]; m_last=(out_idx==3).
  - On m_valid&&m_ready, out_idx increments. After the bin 3 handshake: out_idx→0, frame_cnt+1 (wraps modulo 2^CNT_W), state→LOAD, m_valid=0 next cycle.
- Output register discipline:
  - m_* are registered.
  - While m_valid&&!m_ready, m_re/m_im/m_idx/m_last hold stable.
  - m_valid never drops without a handshake, except on rst.
- Latency: 4th input accepted at cycle N → bin 0 valid at cycle N+2. Minimum frame period is 9 cycles (4 in + 1 compute + 4 out).
- Arithmetic: no scaling or rounding in the controller. Output order is natural (k=0..3), the order produced by fft4.
- Boundaries:
  - s_valid during COMPUTE/UNLOAD is ignored (s_ready=0); the source must hold.
  - m_ready asserted outside UNLOAD has no effect.
  - rst mid-LOAD discards partial samples.
  - rst mid-UNLOAD drops pending bins and does not increment frame_cnt.
  - Full-scale inputs (−2^(W−1) on all four) must not overflow W+2 outputs.

Decomposition:
- Shared package fft4_pkg:
  - parameter-style constants W_DEFAULT=16 and N_POINTS=4.
  - typedef cplx_in_t {logic signed [W-1:0] re, im}.
  - typedef cplx_out_t {logic signed [W+1:0] re, im}.
  - enum ctrl_state_t {LOAD, COMPUTE, UNLOAD}.
- One sub-module: the existing fft4 datapath, instantiated once, driven by the x[0..3] sample registers.
- The FSM, load/out counters and result registers stay in fft4_stream_ctrl.

Test Plan:
- Impulse: stream (1,0),(0,0),(0,0),(0,0) with m_ready=1 → bins 0..3 all (1,0); m_last only on idx 3; bin 0 valid 2 cycles after 4th accept; frame_cnt=1.
- DC: four samples (1,0) → bin0=(4,0), bins 1..3=(0,0).
- Alternating: (1,0),(0,0),(−1,0),(0,0) → (0,0),(2,0),(0,0),(2,0). Full-scale (−32768,0)×4 with W=16 → bin0=(−131072,0) exact.
- Backpressure: m_ready low for 3 cycles on bin 1 → bin 1 data/idx stable throughout, s_ready stays 0, no bin skipped or repeated.
- Gapped input/back-to-back frames: s_valid toggling every other cycle for 2 frames → correct bins for both, frame_cnt=2, no sample accepted while busy=1.
- Reset mid-operation: rst after 2 samples loaded, then a full new frame (1,0)×4 → output bin0=(4,0) (old samples discarded). rst during UNLOAD → m_valid=0 next cycle, frame_cnt unchanged (0 after reset).

Source files
------------

// File: rtl/fft4_pkg.sv
// Shared constants and types for the 4-point FFT streaming controller and its datapath.
// Default widths, the point count, complex sample types and the controller state encoding.
package fft4_pkg;
    localparam int W_DEFAULT = 16;
    localparam int N_POINTS  = 4;

    typedef struct packed {
        logic signed [W_DEFAULT-1:0] re;
        logic signed [W_DEFAULT-1:0] im;
    } cplx_in_t;

    typedef struct packed {
        logic signed [W_DEFAULT+1:0] re;
        logic signed [W_DEFAULT+1:0] im;
    } cplx_out_t;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } ctrl_state_t;
endpackage

// File: rtl/fft4_stream_ctrl_fft4.sv
// Combinational 4-point DFT, natural-order bins, two bits of growth so full scale cannot overflow.
// Zero latency; no flow control (pure function of x).
module fft4
    import fft4_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [N_POINTS*W-1:0]     x_re,
    input  logic [N_POINTS*W-1:0]     x_im,
    output logic [N_POINTS*(W+2)-1:0] y_re,
    output logic [N_POINTS*(W+2)-1:0] y_im
);
    localparam int WO = W + 2;

    logic signed [WO-1:0] ar [N_POINTS];
    logic signed [WO-1:0] ai [N_POINTS];
    logic signed [WO-1:0] s02_re, s02_im, d02_re, d02_im;
    logic signed [WO-1:0] s13_re, s13_im, d13_re, d13_im;
    logic signed [WO-1:0] y0_re, y0_im, y1_re, y1_im, y2_re, y2_im, y3_re, y3_im;

    always_comb begin
        for (int n = 0; n < N_POINTS; n++) begin
            ar[n] = WO'($signed(x_re[n*W +: W]));
            ai[n] = WO'($signed(x_im[n*W +: W]));
        end
    end

    // Radix-2 decomposition: even/odd butterflies, then the -j twiddle on bin 1 and +j on bin 3.
    always_comb begin
        s02_re = ar[0] + ar[2];
        s02_im = ai[0] + ai[2];
        d02_re = ar[0] - ar[2];
        d02_im = ai[0] - ai[2];
        s13_re = ar[1] + ar[3];
        s13_im = ai[1] + ai[3];
        d13_re = ar[1] - ar[3];
        d13_im = ai[1] - ai[3];
        y0_re  = s02_re + s13_re;
        y0_im  = s02_im + s13_im;
        y2_re  = s02_re - s13_re;
        y2_im  = s02_im - s13_im;
        y1_re  = d02_re + d13_im;
        y1_im  = d02_im - d13_re;
        y3_re  = d02_re - d13_im;
        y3_im  = d02_im + d13_re;
    end

    assign y_re = {y3_re, y2_re, y1_re, y0_re};
    assign y_im = {y3_im, y2_im, y1_im, y0_im};
endmodule

// File: rtl/fft4_stream_ctrl.sv
// Streams 4 samples in, runs fft4, streams 4 bins out; bin 0 valid 2 cycles after 4th accept.
// Input stalls (s_ready=0) while busy; output bins hold stable under m_ready backpressure.
module fft4_stream_ctrl
    import fft4_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_re,
    input  logic [W-1:0]     s_im,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W+1:0]     m_re,
    output logic [W+1:0]     m_im,
    output logic [1:0]       m_idx,
    output logic             m_last,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);
    localparam int         WO       = W + 2;
    localparam logic [1:0] LAST_IDX = 2'(N_POINTS - 1);

    ctrl_state_t              state_q, state_d;
    logic [1:0]               load_idx_q, load_idx_d;
    logic [1:0]               out_idx_q, out_idx_d;
    logic [1:0]               out_nxt;
    logic [N_POINTS*W-1:0]    x_re_q, x_re_d, x_im_q, x_im_d;
    logic [N_POINTS*WO-1:0]   y_re_q, y_re_d, y_im_q, y_im_d;
    logic [N_POINTS*WO-1:0]   fft_re, fft_im;
    logic                     m_valid_q, m_valid_d;
    logic [WO-1:0]            m_re_q, m_re_d, m_im_q, m_im_d;
    logic [1:0]               m_idx_q, m_idx_d;
    logic                     m_last_q, m_last_d;
    logic                     busy_q, busy_d;
    logic                     s_ready_q, s_ready_d;
    logic [CNT_W-1:0]         frame_cnt_q, frame_cnt_d;

    fft4 #(.W(W)) u_fft4 (
        .x_re (x_re_q),
        .x_im (x_im_q),
        .y_re (fft_re),
        .y_im (fft_im)
    );

    always_comb begin
        state_d     = state_q;
        load_idx_d  = load_idx_q;
        out_idx_d   = out_idx_q;
        out_nxt     = out_idx_q + 2'd1;
        x_re_d      = x_re_q;
        x_im_d      = x_im_q;
        y_re_d      = y_re_q;
        y_im_d      = y_im_q;
        m_valid_d   = m_valid_q;
        m_re_d      = m_re_q;
        m_im_d      = m_im_q;
        m_idx_d     = m_idx_q;
        m_last_d    = m_last_q;
        busy_d      = busy_q;
        s_ready_d   = s_ready_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            LOAD: begin
                if (s_valid && s_ready_q) begin
                    x_re_d[int'(load_idx_q)*W +: W] = s_re;
                    x_im_d[int'(load_idx_q)*W +: W] = s_im;
                    load_idx_d = load_idx_q + 2'd1;
                    if (load_idx_q == LAST_IDX) begin
                        state_d   = COMPUTE;
                        s_ready_d = 1'b0;
                        busy_d    = 1'b1;
                    end
                end
            end
            COMPUTE: begin
                // Bin 0 goes straight from the datapath so it is valid on the first UNLOAD cycle.
                y_re_d    = fft_re;
                y_im_d    = fft_im;
                m_valid_d = 1'b1;
                m_re_d    = fft_re[0 +: WO];
                m_im_d    = fft_im[0 +: WO];
                m_idx_d   = 2'd0;
                m_last_d  = 1'b0;
                out_idx_d = 2'd0;
                state_d   = UNLOAD;
            end
            UNLOAD: begin
                if (m_ready) begin
                    if (out_idx_q == LAST_IDX) begin
                        out_idx_d   = 2'd0;
                        m_valid_d   = 1'b0;
                        m_last_d    = 1'b0;
                        busy_d      = 1'b0;
                        s_ready_d   = 1'b1;
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        state_d     = LOAD;
                    end else begin
                        out_idx_d = out_nxt;
                        m_re_d    = y_re_q[int'(out_nxt)*WO +: WO];
                        m_im_d    = y_im_q[int'(out_nxt)*WO +: WO];
                        m_idx_d   = out_nxt;
                        m_last_d  = (out_nxt == LAST_IDX);
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            load_idx_q  <= '0;
            out_idx_q   <= '0;
            x_re_q      <= '0;
            x_im_q      <= '0;
            y_re_q      <= '0;
            y_im_q      <= '0;
            m_valid_q   <= 1'b0;
            m_re_q      <= '0;
            m_im_q      <= '0;
            m_idx_q     <= '0;
            m_last_q    <= 1'b0;
            busy_q      <= 1'b0;
            s_ready_q   <= 1'b1;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            load_idx_q  <= load_idx_d;
            out_idx_q   <= out_idx_d;
            x_re_q      <= x_re_d;
            x_im_q      <= x_im_d;
            y_re_q      <= y_re_d;
            y_im_q      <= y_im_d;
            m_valid_q   <= m_valid_d;
            m_re_q      <= m_re_d;
            m_im_q      <= m_im_d;
            m_idx_q     <= m_idx_d;
            m_last_q    <= m_last_d;
            busy_q      <= busy_d;
            s_ready_q   <= s_ready_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_re      = m_re_q;
    assign m_im      = m_im_q;
    assign m_idx     = m_idx_q;
    assign m_last    = m_last_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_fft4_stream_ctrl.sv
// Bench for fft4_stream_ctrl: DFT reference model on accepted samples, per-cycle output compare,
// directed frames with literal bins, backpressure, gapped input, resets mid-load and mid-unload.
module tb_fft4_stream_ctrl;
    localparam int W     = 16;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             s_valid;
    logic             s_ready;
    logic [W-1:0]     s_re, s_im;
    logic             m_valid;
    logic             m_ready;
    logic [W+1:0]     m_re, m_im;
    logic [1:0]       m_idx;
    logic             m_last;
    logic             busy;
    logic [CNT_W-1:0] frame_cnt;

    always #5 clk = ~clk;

    fft4_stream_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
        .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im),
        .m_idx(m_idx), .m_last(m_last), .busy(busy), .frame_cnt(frame_cnt)
    );

    typedef struct {
        int re;
        int im;
        int idx;
    } bin_t;

    bin_t expq[$];
    int   smp_re[$], smp_im[$];
    int   log_re[$], log_im[$];
    int   checks = 0, errors = 0;
    int   model_frames = 0;
    int   cyc = 0, last_accept_cyc = 0;
    int   rdy_mode = 0, stall = 0;
    logic prev_rst = 1'b0, prev_vld = 1'b0, prev_rdy = 1'b0, prev_last = 1'b0;
    logic [W+1:0] prev_re = '0, prev_im = '0;
    logic [1:0]   prev_idx = '0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Direct DFT: X[k] = sum x[n] * (-j)^(n*k mod 4).
    function automatic void push_frame();
        for (int k = 0; k < 4; k++) begin
            bin_t b;
            b.re = 0; b.im = 0; b.idx = k;
            for (int n = 0; n < 4; n++) begin
                case ((n * k) % 4)
                    0: begin b.re += smp_re[n]; b.im += smp_im[n]; end
                    1: begin b.re += smp_im[n]; b.im -= smp_re[n]; end
                    2: begin b.re -= smp_re[n]; b.im -= smp_im[n]; end
                    default: begin b.re -= smp_im[n]; b.im += smp_re[n]; end
                endcase
            end
            expq.push_back(b);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            smp_re.delete(); smp_im.delete(); expq.delete();
            model_frames = 0;
            prev_rst = 1'b1;
            prev_vld = 1'b0;
            prev_rdy = 1'b0;
        end else begin
            if (prev_rst) begin
                chk("rst_m_valid", m_valid, 0);
                chk("rst_s_ready", s_ready, 1);
                chk("rst_busy", busy, 0);
                chk("rst_m_re", int'($signed(m_re)), 0);
                chk("rst_m_im", int'($signed(m_im)), 0);
                chk("rst_m_idx", m_idx, 0);
                chk("rst_m_last", m_last, 0);
            end
            chk("frame_cnt", int'(frame_cnt), model_frames % (1 << CNT_W));
            if (m_valid) begin
                chk("busy_in_unload", busy, 1);
                chk("s_ready_in_unload", s_ready, 0);
            end
            if (s_ready) chk("busy_with_s_ready", busy, 0);
            if (prev_vld && !prev_rdy) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_re", int'(m_re), int'(prev_re));
                chk("hold_im", int'(m_im), int'(prev_im));
                chk("hold_idx", m_idx, prev_idx);
                chk("hold_last", m_last, prev_last);
            end
            if (m_valid) begin
                if (!prev_vld) chk("latency", cyc - last_accept_cyc, 2);
                if (expq.size() == 0) begin
                    chk("spurious_bin", 1, 0);
                end else begin
                    chk("bin_re", int'($signed(m_re)), expq[0].re);
                    chk("bin_im", int'($signed(m_im)), expq[0].im);
                    chk("bin_idx", m_idx, expq[0].idx);
                    chk("bin_last", m_last, expq[0].idx == 3);
                    if (m_ready) begin
                        log_re.push_back(int'($signed(m_re)));
                        log_im.push_back(int'($signed(m_im)));
                        if (expq[0].idx == 3) model_frames++;
                        void'(expq.pop_front());
                    end
                end
            end
            if (s_valid && s_ready) begin
                smp_re.push_back(int'($signed(s_re)));
                smp_im.push_back(int'($signed(s_im)));
                if (smp_re.size() == 4) begin
                    push_frame();
                    last_accept_cyc = cyc;
                    smp_re.delete(); smp_im.delete();
                end
            end
            prev_rst  = 1'b0;
            prev_vld  = m_valid;
            prev_rdy  = m_ready;
            prev_re   = m_re;
            prev_im   = m_im;
            prev_idx  = m_idx;
            prev_last = m_last;
        end
    end

    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: m_ready = 1'b1;
                1: m_ready = 1'($urandom_range(0, 1));
                2: if (m_valid && m_idx == 2'd1 && stall < 3) begin
                       m_ready = 1'b0;
                       stall++;
                   end else begin
                       m_ready = 1'b1;
                   end
                default: m_ready = 1'b0;
            endcase
        end
    end

    task automatic send_sample(input int re, input int im);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_re = W'(re);
        s_im = W'(im);
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 400) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_rand_frame(input int max_gap);
        for (int i = 0; i < 4; i++) begin
            send_sample(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while (model_frames < target && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_frames_reached", int'(model_frames >= target), 1);
    endtask

    task automatic check_bins(input string nm, input int b0, input int b1, input int b2, input int b3);
        int e[4];
        int base;
        e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3;
        if (log_re.size() < 4) begin
            chk({nm, "_count"}, log_re.size(), 4);
        end else begin
            base = log_re.size() - 4;
            for (int k = 0; k < 4; k++) begin
                chk({nm, "_re"}, log_re[base + k], e[k]);
                chk({nm, "_im"}, log_im[base + k], 0);
            end
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int base;
        rst = 1'b1; s_valid = 1'b0; s_re = '0; s_im = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        rdy_mode = 0;
        send_sample(1, 0); send_sample(0, 0); send_sample(0, 0); send_sample(0, 0);
        wait_frames(1);
        check_bins("impulse", 1, 1, 1, 1);
        chk("impulse_frame_cnt", int'(frame_cnt), 1);

        for (int i = 0; i < 4; i++) send_sample(1, 0);
        wait_frames(2);
        check_bins("dc", 4, 0, 0, 0);

        send_sample(1, 0); send_sample(0, 0); send_sample(-1, 0); send_sample(0, 0);
        wait_frames(3);
        check_bins("alternating", 0, 2, 0, 2);

        for (int i = 0; i < 4; i++) send_sample(-32768, 0);
        wait_frames(4);
        check_bins("full_scale", -131072, 0, 0, 0);

        stall = 0;
        rdy_mode = 2;
        send_rand_frame(0);
        wait_frames(5);
        chk("backpressure_stalls", stall, 3);
        rdy_mode = 0;

        base = model_frames;
        send_rand_frame(1);
        send_rand_frame(1);
        wait_frames(base + 2);
        chk("gapped_frame_cnt", int'(frame_cnt), base + 2);

        rdy_mode = 1;
        base = model_frames;
        for (int f = 0; f < 12; f++) send_rand_frame(2);
        wait_frames(base + 12);
        rdy_mode = 0;

        send_sample(7, -3); send_sample(-9, 5);
        pulse_rst();
        for (int i = 0; i < 4; i++) send_sample(1, 0);
        wait_frames(1);
        check_bins("rst_mid_load", 4, 0, 0, 0);

        rdy_mode = 3;
        send_rand_frame(0);
        for (int n = 0; n < 20 && !m_valid; n++) begin
            @(posedge clk);
            #1;
        end
        chk("unload_reached", m_valid, 1);
        pulse_rst();
        @(negedge clk);
        chk("rst_unload_m_valid", m_valid, 0);
        chk("rst_unload_frame_cnt", int'(frame_cnt), 0);
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;

        chk("drained_expected", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
